// File: rtl/onehot_mux_pipe.sv
// onehot_mux_pipe
//   N_IN-input, WIDTH-bit one-hot select mux with a registered, handshaked
//   output stage. It is built on a 2-entry skid buffer (main + skid register),
//   so it sustains one beat per cycle and has no combinational path from any
//   input to any output. Each beat's select is checked. A beat whose select is
//   not one-hot is flagged on out_err and counted in a saturating counter.
//
// Handshake: a beat moves on a rising clk edge when valid and ready are both
//   high on that side. Once out_valid is asserted it stays high, and
//   out_data/out_err stay unchanged, until the beat is taken (out_ready=1).
//   in_valid does not depend on in_ready.
//
// Ports
//   clk        clock, rising edge
//   resetn     asynchronous active-low reset
//   in_valid   upstream beat valid
//   in_ready   block can accept a beat (register output)
//   in_data    flattened inputs, input i = in_data[i*WIDTH +: WIDTH]
//   sel        one-hot select, sampled with the beat
//   out_valid  downstream beat valid (register output)
//   out_ready  downstream accepts
//   out_data   selected data of the head beat (register output)
//   out_err    head beat had a non-one-hot select (register output)
//   err_clr    synchronous clear of err_cnt
//   err_cnt    saturating count of accepted illegal-select beats
//   dbg_state  buffer occupancy state (0 EMPTY, 1 ONE, 2 TWO)
module onehot_mux_pipe #(
  parameter int N_IN     = 5,
  parameter int WIDTH    = 32,
  parameter int ERR_MODE = 0,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             accept;
  logic [WIDTH-1:0] mux_val;
  logic [WIDTH-1:0] beat_data;
  logic             illegal;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic             load_main_new, load_main_skid, load_skid;
  logic             in_ready_d, out_valid_d;

  assign accept    = in_valid & in_ready;
  assign dbg_state = state_q;

  // AND-OR mux. It gives the raw OR of all selected inputs when more than one
  // select bit is set.
  always_comb begin
    mux_val = '0;
    for (int i = 0; i < N_IN; i++) begin
      mux_val = mux_val | (in_data[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
    end
  end

  // sel & (sel-1) clears the lowest set bit. A non-zero result means two or
  // more bits were set.
  assign illegal   = (sel == '0) || ((sel & (sel - N_IN'(1))) != '0);
  assign beat_data = ((ERR_MODE != 0) && illegal) ? '0 : mux_val;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  // Next-state and load-enable logic
  always_comb begin
    state_d        = state_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d       = ONE;
          load_main_new = 1'b1;
        end
      end
      ONE: begin
        if (accept && out_ready) begin
          load_main_new = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_ready) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output decode. It is computed from the next state so that in_ready and
  // out_valid can be registered. in_ready resets low and rises on the first
  // edge after reset is released.
  always_comb begin
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Main register drives the outputs. The skid register holds the second beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_main_new) begin
        out_data <= beat_data;
        out_err  <= illegal;
      end else if (load_main_skid) begin
        out_data <= skid_data;
        out_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= beat_data;
        skid_err  <= illegal;
      end
    end
  end

  // Saturating illegal-select counter. A clear in the same cycle as an
  // illegal accept leaves the count at 1, so that beat is not lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= (accept && illegal) ? CNT_W'(1) : '0;
    end else if (accept && illegal && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_onehot_mux_pipe.sv
module tb_onehot_mux_pipe;
  localparam int N  = 5;
  localparam int W  = 32;
  localparam int CW = 8;
  localparam int CNT_SAT = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic           in_valid = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   sel = '0;
  logic           out_ready = 1'b0;
  logic           err_clr = 1'b0;

  logic           in_ready0, in_ready1, out_valid0, out_valid1, out_err0, out_err1;
  logic [W-1:0]   out_data0, out_data1;
  logic [CW-1:0]  err_cnt0, err_cnt1;
  logic [1:0]     dbg0, dbg1;

  onehot_mux_pipe #(.N_IN(N), .WIDTH(W), .ERR_MODE(0), .CNT_W(CW)) u_dut0 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .sel(sel), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_err(out_err0), .err_clr(err_clr),
    .err_cnt(err_cnt0), .dbg_state(dbg0)
  );

  onehot_mux_pipe #(.N_IN(N), .WIDTH(W), .ERR_MODE(1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .sel(sel), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_err(out_err1), .err_clr(err_clr),
    .err_cnt(err_cnt1), .dbg_state(dbg1)
  );

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];   // expected data, ERR_MODE=0 instance
  logic [W-1:0] exp1_q[$];  // expected data, ERR_MODE=1 instance
  logic         experr_q[$];
  logic [W-1:0] got_q[$];   // data actually delivered by instance 0
  int           exp_cnt;
  bit           armed;
  bit           last_fi;
  int           n_tests = 0;
  int           n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_mux(input logic [N-1:0] s, input logic [N*W-1:0] d);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) if (s[i]) r = r | d[i*W +: W];
    return r;
  endfunction

  task automatic check_state();
    int sz = exp_q.size();
    chk("out_valid0", 64'(out_valid0), 64'(sz > 0));
    chk("out_valid1", 64'(out_valid1), 64'(sz > 0));
    chk("in_ready0", 64'(in_ready0), 64'(sz < 2));
    chk("in_ready1", 64'(in_ready1), 64'(sz < 2));
    if (sz > 0) begin
      chk("out_data0", 64'(out_data0), 64'(exp_q[0]));
      chk("out_data1", 64'(out_data1), 64'(exp1_q[0]));
      chk("out_err0", 64'(out_err0), 64'(experr_q[0]));
      chk("out_err1", 64'(out_err1), 64'(experr_q[0]));
    end
    chk("err_cnt0", 64'(err_cnt0), 64'(exp_cnt));
    chk("err_cnt1", 64'(err_cnt1), 64'(exp_cnt));
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, lets one rising edge pass, updates the model
  // and checks every output 1 time unit after that edge.
  task automatic step(input logic v, input logic [N-1:0] s, input logic [N*W-1:0] d,
                      input logic ordy, input logic clr);
    logic fi, fo, ill;
    logic [W-1:0] m;
    in_valid = v; sel = s; in_data = d; out_ready = ordy; err_clr = clr;
    fo  = (exp_q.size() > 0) && ordy;
    fi  = v && armed && (exp_q.size() < 2);
    ill = ($countones(s) != 1);
    m   = ref_mux(s, d);
    if (out_valid0 && ordy) got_q.push_back(out_data0);
    @(posedge clk); #1;
    if (fo) begin
      void'(exp_q.pop_front()); void'(exp1_q.pop_front()); void'(experr_q.pop_front());
    end
    if (fi) begin
      exp_q.push_back(m);
      exp1_q.push_back(ill ? '0 : m);
      experr_q.push_back(ill);
    end
    if (clr)                            exp_cnt = (fi && ill) ? 1 : 0;
    else if (fi && ill && exp_cnt < CNT_SAT) exp_cnt++;
    armed   = 1'b1;
    last_fi = fi;
    check_state();
  endtask

  task automatic model_reset();
    exp_q.delete(); exp1_q.delete(); experr_q.delete(); got_q.delete();
    exp_cnt = 0;
    armed   = 1'b0;
  endtask

  task automatic reset_dut();
    in_valid = 0; out_ready = 0; err_clr = 0; sel = '0; in_data = '0;
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    chk("rst_out_valid", 64'(out_valid0), 64'(0));
    chk("rst_in_ready", 64'(in_ready0), 64'(0));
    chk("rst_out_data", 64'(out_data0), 64'(0));
    chk("rst_out_err", 64'(out_err0), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt1), 64'(0));
    chk("rst_state", 64'(dbg0), 64'(0));
  endtask

  function automatic logic [N*W-1:0] pack1(input logic [W-1:0] v);
    logic [N*W-1:0] d = '0;
    d[1*W +: W] = v;
    return d;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] sel;
    logic [W-1:0] exp0;
    logic [W-1:0] exp1;
    logic         err;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] tdat;
    logic [N*W-1:0] rd;
    logic [N-1:0]   rs;
    int sent;
    bit saw_stall;

    tdat = {32'hF000_0000, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0002, 32'h0000_0001};
    tbl[0] = '{5'b00100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{5'b00001, 32'h0000_0001, 32'h0000_0001, 1'b0};
    tbl[2] = '{5'b00010, 32'h0000_0002, 32'h0000_0002, 1'b0};
    tbl[3] = '{5'b01000, 32'h0000_0100, 32'h0000_0100, 1'b0};
    tbl[4] = '{5'b10000, 32'hF000_0000, 32'hF000_0000, 1'b0};
    tbl[5] = '{5'b00000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[6] = '{5'b00011, 32'h0000_0003, 32'h0000_0000, 1'b1};
    tbl[7] = '{5'b10001, 32'hF000_0001, 32'h0000_0000, 1'b1};
    tbl[8] = '{5'b11111, 32'hFEAD_BFEF, 32'h0000_0000, 1'b1};

    // Test 1: first beat after reset release
    reset_dut();
    step(1, 5'b00100, tdat, 1, 0);
    chk("t1_in_ready_rise", 64'(in_ready0), 64'(1));
    step(1, 5'b00100, tdat, 1, 0);
    chk("t1_out_valid", 64'(out_valid0), 64'(1));
    chk("t1_out_data", 64'(out_data0), 64'(32'hDEAD_BEEF));
    chk("t1_out_err", 64'(out_err0), 64'(0));

    // Table-driven vectors at full throughput
    reset_dut();
    step(0, '0, '0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      step(1, tbl[i].sel, tdat, 1, 0);
      chk($sformatf("tbl%0d_data0", i), 64'(out_data0), 64'(tbl[i].exp0));
      chk($sformatf("tbl%0d_data1", i), 64'(out_data1), 64'(tbl[i].exp1));
      chk($sformatf("tbl%0d_err", i), 64'(out_err0), 64'(tbl[i].err));
    end
    chk("tbl_err_cnt", 64'(err_cnt0), 64'(4));

    // Test 2: stream 0..9 with a downstream stall in cycles 3-5
    reset_dut();
    step(0, '0, '0, 1, 0);
    got_q.delete();
    sent = 0;
    saw_stall = 0;
    for (int c = 0; c < 30; c++) begin
      step(sent < 10, 5'b00010, pack1(W'(sent)), !(c >= 3 && c <= 5), 0);
      if (last_fi) sent++;
      if (!in_ready0) saw_stall = 1;
    end
    chk("t2_saw_in_ready_low", 64'(saw_stall), 64'(1));
    chk("t2_count", 64'(got_q.size()), 64'(10));
    for (int i = 0; i < 10 && i < got_q.size(); i++)
      chk($sformatf("t2_order%0d", i), 64'(got_q[i]), 64'(i));

    // Test 3: illegal selects with raw AND-OR result
    reset_dut();
    step(0, '0, '0, 1, 0);
    step(1, 5'b00000, tdat, 1, 0);
    chk("t3_zero_data", 64'(out_data0), 64'(0));
    chk("t3_zero_err", 64'(out_err0), 64'(1));
    step(1, 5'b00011, tdat, 1, 0);
    chk("t3_or_data", 64'(out_data0), 64'(3));
    chk("t3_or_err", 64'(out_err0), 64'(1));
    chk("t3_err_cnt", 64'(err_cnt0), 64'(2));

    // Test 4: forced-zero mode, saturation and clear
    reset_dut();
    step(0, '0, '0, 1, 0);
    step(1, 5'b10001, tdat, 1, 0);
    chk("t4_mode1_data", 64'(out_data1), 64'(0));
    chk("t4_mode1_err", 64'(out_err1), 64'(1));
    for (int i = 0; i < 299; i++) step(1, 5'b10001, tdat, 1, 0);
    chk("t4_saturate", 64'(err_cnt1), 64'(255));
    step(1, 5'b00100, tdat, 1, 1);
    chk("t4_clr_legal", 64'(err_cnt1), 64'(0));
    step(1, 5'b10001, tdat, 1, 1);
    chk("t4_clr_illegal", 64'(err_cnt1), 64'(1));

    // Test 5: asynchronous reset while both entries are full
    reset_dut();
    step(0, '0, '0, 1, 0);
    step(1, 5'b00010, pack1(32'hAAAA_0001), 0, 0);
    step(1, 5'b00000, pack1(32'hAAAA_0002), 0, 0);
    chk("t5_state_two", 64'(dbg0), 64'(2));
    #2 resetn = 1'b0;
    #1;
    chk("t5_async_valid", 64'(out_valid0), 64'(0));
    chk("t5_async_cnt", 64'(err_cnt0), 64'(0));
    chk("t5_async_state", 64'(dbg0), 64'(0));
    model_reset();
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1 resetn = 1'b1;
    for (int i = 0; i < 4; i++) step(0, '0, '0, 1, 0);
    chk("t5_no_ghost_beats", 64'(got_q.size()), 64'(0));

    // Test 6: randomized traffic against the queue model
    reset_dut();
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 7) < 6) rs = N'(1) << $urandom_range(0, N - 1);
      else                          rs = N'($urandom_range(0, 31));
      for (int i = 0; i < N; i++) rd[i*W +: W] = $urandom;
      step($urandom_range(0, 3) != 0, rs, rd, $urandom_range(0, 3) != 0,
           $urandom_range(0, 63) == 0);
    end
    // Drain
    for (int c = 0; c < 4; c++) step(0, '0, '0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
